// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the 50 MHz / 9600 baud timing
// constants used by both the transmitter and the receiver.
package uart_pkg;

  localparam int CLK_HZ               = 50_000_000;
  localparam int BAUD                 = 9600;
  localparam int DEFAULT_CLKS_PER_BIT = CLK_HZ / BAUD;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// N-flop synchroniser for an asynchronous level input; resets to 1 so an idle-high
// serial line does not look like a start edge when reset is released.
module uart_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] ff_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain to one flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_q <= '1;
    end else begin
      ff_q <= {ff_q[N-2:0], d};
    end
  end

  assign q = ff_q[N-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx_line, finds the start edge, samples each bit at
// mid-bit and publishes the byte with a one-cycle valid strobe (or a frame_err strobe).
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_line,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic            rx_s;
  rx_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      sh_q, sh_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            frame_err_q, frame_err_d;

  uart_sync #(
    .N (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_line),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      sh_q        <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sh_q        <= sh_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave one
    // unassigned and infer a latch; the strobes default low to make them single-cycle.
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    sh_d        = sh_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            idx_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d       = '0;
          sh_d[idx_q] = rx_s;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = sh_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BREAK: begin
        // A line held low must go high before the next start edge can be armed.
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: clean frames, back-to-back frames,
// glitch rejection, framing error with break, mid-frame reset and baud-rate error.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CPB     = 16;
  localparam int SYNC    = 2;
  localparam int HALF    = CPB / 2;
  localparam int BIT_NS  = CPB * 10;
  localparam int LAT_NOM = SYNC + HALF + 9 * CPB;

  logic       clk;
  logic       rst_n;
  logic       rx_line;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int fe_cnt = 0;
  int both_cnt = 0;
  int valid_cyc = 0;
  int fall_cyc = 0;
  logic [7:0] got_q[$];

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_line   (rx_line),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Output monitor samples 1 ns after each rising edge.
  always begin
    @(posedge clk);
    #1;
    if (valid) begin
      valid_cnt++;
      got_q.push_back(data);
      valid_cyc = cyc;
    end
    if (frame_err) fe_cnt++;
    if (valid && frame_err) both_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_frame(input logic [7:0] b, input int bit_ns, input logic stop_bit);
    rx_line  = 1'b0;
    fall_cyc = cyc;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      #(bit_ns);
    end
    rx_line = stop_bit;
    #(bit_ns);
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    rx_line = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single_byte();
    int v0, f0, lat;
    v0 = valid_cnt;
    f0 = fe_cnt;
    @(negedge clk);
    send_frame(8'hA5, BIT_NS, 1'b1);
    repeat (4) @(negedge clk);
    lat = valid_cyc - fall_cyc;
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL a5_valid_count got %0d want 1", valid_cnt - v0); end
    checks++; if (data !== 8'hA5) begin errors++; $display("FAIL a5_data got %h want a5", data); end
    checks++; if (fe_cnt - f0 !== 0) begin errors++; $display("FAIL a5_frame_err got %0d want 0", fe_cnt - f0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL a5_busy_after got %b want 0", busy); end
    checks++;
    if (lat < LAT_NOM - 1 || lat > LAT_NOM + 1) begin
      errors++; $display("FAIL a5_latency got %0d want %0d+/-1", lat, LAT_NOM);
    end
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = valid_cnt;
    got_q.delete();
    @(negedge clk);
    send_frame(8'h00, BIT_NS, 1'b1);
    send_frame(8'hFF, BIT_NS, 1'b1);
    repeat (4) @(negedge clk);
    checks++; if (valid_cnt - v0 !== 2) begin errors++; $display("FAIL b2b_valid_count got %0d want 2", valid_cnt - v0); end
    checks++;
    if ((got_q.size() > 0 ? got_q[0] : 8'hxx) !== 8'h00) begin
      errors++; $display("FAIL b2b_first got %h want 00", (got_q.size() > 0 ? got_q[0] : 8'hxx));
    end
    checks++;
    if ((got_q.size() > 1 ? got_q[1] : 8'hxx) !== 8'hFF) begin
      errors++; $display("FAIL b2b_second got %h want ff", (got_q.size() > 1 ? got_q[1] : 8'hxx));
    end
  endtask

  task automatic test_glitch();
    int v0, f0, n;
    v0 = valid_cnt;
    f0 = fe_cnt;
    @(negedge clk);
    rx_line = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_rise got %b want 1", busy); end
    rx_line = 1'b1;
    n = 0;
    while (busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_fall got %b want 0 within 10 cycles", busy); end
    repeat (2 * CPB) @(negedge clk);
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL glitch_valid got %0d want 0", valid_cnt - v0); end
    checks++; if (fe_cnt - f0 !== 0) begin errors++; $display("FAIL glitch_frame_err got %0d want 0", fe_cnt - f0); end
  endtask

  task automatic test_frame_error();
    int v0, f0;
    v0 = valid_cnt;
    f0 = fe_cnt;
    @(negedge clk);
    send_frame(8'h3C, BIT_NS, 1'b0);
    repeat (40) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL break_busy_held got %b want 1", busy); end
    rx_line = 1'b1;
    checks++; if (fe_cnt - f0 !== 1) begin errors++; $display("FAIL fe_count got %0d want 1", fe_cnt - f0); end
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL fe_no_valid got %0d want 0", valid_cnt - v0); end
    checks++; if (data !== 8'hFF) begin errors++; $display("FAIL fe_data_held got %h want ff", data); end
    repeat (20) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_exit got %b want 0", busy); end
    send_frame(8'h81, BIT_NS, 1'b1);
    repeat (4) @(negedge clk);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL after_break_valid got %0d want 1", valid_cnt - v0); end
    checks++; if (data !== 8'h81) begin errors++; $display("FAIL after_break_data got %h want 81", data); end
    checks++; if (fe_cnt - f0 !== 1) begin errors++; $display("FAIL after_break_fe got %0d want 1", fe_cnt - f0); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    int v0;
    b  = 8'h5A;
    v0 = valid_cnt;
    @(negedge clk);
    rx_line = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      rx_line = b[i];
      #(BIT_NS);
    end
    rx_line = b[4];
    #(BIT_NS / 2);
    rst_n = 1'b0;
    #1;
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL midrst_data got %h want 00", data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    checks++; if (valid !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL midrst_strobes got %b%b want 00", valid, frame_err);
    end
    rx_line = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL midrst_no_valid got %0d want 0", valid_cnt - v0); end
    send_frame(8'hC3, BIT_NS, 1'b1);
    repeat (4) @(negedge clk);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL midrst_c3_valid got %0d want 1", valid_cnt - v0); end
    checks++; if (data !== 8'hC3) begin errors++; $display("FAIL midrst_c3_data got %h want c3", data); end
  endtask

  // Bit periods of 15.4 and 16.6 clocks against a receiver expecting 16.
  task automatic test_baud_error();
    int periods[2];
    int v0, lat;
    periods[0] = 154;
    periods[1] = 166;
    for (int k = 0; k < 2; k++) begin
      v0 = valid_cnt;
      @(negedge clk);
      send_frame(8'h96, periods[k], 1'b1);
      repeat (4) @(negedge clk);
      lat = valid_cyc - fall_cyc;
      checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL baud%0d_valid got %0d want 1", periods[k], valid_cnt - v0); end
      checks++; if (data !== 8'h96) begin errors++; $display("FAIL baud%0d_data got %h want 96", periods[k], data); end
      checks++;
      if (lat < LAT_NOM - 1 || lat > LAT_NOM + 1) begin
        errors++; $display("FAIL baud%0d_latency got %0d want %0d+/-1", periods[k], lat, LAT_NOM);
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    rx_line = 1'b1;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_mid_frame();
    test_baud_error();
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL valid_and_fe_overlap got %0d want 0", both_cnt); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
